fxp_layer_engine: RTL and testbench



---
 rtl/fxp_layer_engine_if.sv | 63 ++++++
 rtl/fxp_layer_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_fxp_layer_engine.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fxp_layer_engine_if.sv
// ----------------------------------------------------------------------------
// fxp_layer_engine_if
// Host-side bus of the fixed-point layer engine: weight/bias writes, input
// vector writes, start/busy/done handshake and output readback.
//
// Signals:
//   cfg_we / cfg_addr / cfg_data : weight/bias store write (word = n*(N_IN+1)+k,
//                                  k == N_IN is the bias)
//   in_we / in_addr / in_data    : input vector write
//   start                        : one-cycle evaluation request
//   busy / done                  : evaluation in progress / one-cycle completion
//   out_addr / out_data          : output index / registered output value
//   cycle_count                  : busy cycles of the last evaluation
//   act_sel                      : activation select (only with FXP_ACT_SEL_EN)
//
// Modports: master = host/software side, slave = engine.
// ----------------------------------------------------------------------------
interface fxp_layer_engine_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 2
);
    localparam int unsigned DEPTH  = N_OUT * (N_IN + 1);
    localparam int unsigned CFG_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IN_AW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                     cfg_we;
    logic [CFG_AW-1:0]        cfg_addr;
    logic signed [DATA_W-1:0] cfg_data;
    logic                     in_we;
    logic [IN_AW-1:0]         in_addr;
    logic signed [DATA_W-1:0] in_data;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [OUT_AW-1:0]        out_addr;
    logic signed [DATA_W-1:0] out_data;
    logic [31:0]              cycle_count;
`ifdef FXP_ACT_SEL_EN
    logic [1:0]               act_sel;
`endif

    modport master (
`ifdef FXP_ACT_SEL_EN
        output act_sel,
`endif
        output cfg_we, cfg_addr, cfg_data,
        output in_we, in_addr, in_data,
        output start, out_addr,
        input  busy, done, out_data, cycle_count
    );

    modport slave (
`ifdef FXP_ACT_SEL_EN
        input  act_sel,
`endif
        input  cfg_we, cfg_addr, cfg_data,
        input  in_we, in_addr, in_data,
        input  start, out_addr,
        output busy, done, out_data, cycle_count
    );
endinterface

// File: rtl/fxp_layer_engine.sv
// ----------------------------------------------------------------------------
// fxp_layer_engine
// Time-multiplexed fixed-point fully-connected layer: N_OUT neurons over N_IN
// inputs using one shared MAC, an on-chip weight/bias store and an input
// vector store. Each neuron takes N_IN MAC cycles plus one activation cycle.
//
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset (clears all state and storage)
//   bus   : fxp_layer_engine_if.slave (config/input writes, start/busy/done,
//           output read, cycle_count)
//
// Optional feature macro: FXP_ACT_SEL_EN
//   Defined   : bus.act_sel picks the activation, sampled at an accepted start
//               (0/3 hard sigmoid, 1 ReLU, 2 identity).
//   Undefined : activation is always hard sigmoid.
// ----------------------------------------------------------------------------
module fxp_layer_engine #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 10,
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned ACC_W  = 40
) (
    input  logic              clk,
    input  logic              reset,
    fxp_layer_engine_if.slave bus
);
    localparam int unsigned DEPTH  = N_OUT * (N_IN + 1);
    localparam int unsigned CFG_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IN_AW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned NEU_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned PROD_W = 2 * DATA_W;

    // Hard-sigmoid constants 0.5 and 1.0, one bit wider than the data path.
    localparam logic signed [DATA_W:0] SIG_HALF =
        {{(DATA_W - FRAC_W + 1){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};
    localparam logic signed [DATA_W:0] SIG_ONE =
        {{(DATA_W - FRAC_W){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StAct, StFin} state_e;

    state_e r_state;
    state_e w_state_next;

    logic signed [DATA_W-1:0] r_wmem [DEPTH];
    logic signed [DATA_W-1:0] r_xmem [N_IN];
    logic signed [DATA_W-1:0] r_out  [N_OUT];
    logic signed [DATA_W-1:0] r_out_data;
    logic signed [ACC_W-1:0]  r_acc;
    logic [NEU_W-1:0]         r_neuron;
    logic [IN_AW-1:0]         r_k;
    logic [CFG_AW-1:0]        r_base;     // store index of the current neuron's first weight
    logic [31:0]              r_cycle_count;
`ifdef FXP_ACT_SEL_EN
    logic [1:0]               r_act_sel;
`endif

    logic                     w_busy;
    logic                     w_start_ok;
    logic                     w_k_last;
    logic                     w_neuron_last;
    logic [CFG_AW-1:0]        w_widx;
    logic [CFG_AW-1:0]        w_bidx;
    logic signed [DATA_W-1:0] w_wt;
    logic signed [DATA_W-1:0] w_xin;
    logic signed [DATA_W-1:0] w_bias;
    logic signed [PROD_W-1:0] w_wt_ext;
    logic signed [PROD_W-1:0] w_x_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_shift;
    logic [ACC_W-DATA_W:0]    w_hi;
    logic signed [DATA_W-1:0] w_s;
    logic signed [DATA_W:0]   w_s_wide;
    logic signed [DATA_W:0]   w_sig_pre;
    logic signed [DATA_W-1:0] w_sig;
    logic signed [DATA_W-1:0] w_act;

    assign w_busy        = (r_state == StMac) || (r_state == StAct);
    assign w_start_ok    = (r_state == StIdle) && bus.start;
    assign w_k_last      = (r_k == IN_AW'(N_IN - 1));
    assign w_neuron_last = (r_neuron == NEU_W'(N_OUT - 1));

    // ---------------- MAC operand fetch and product ----------------
    assign w_widx   = r_base + CFG_AW'(r_k);
    assign w_bidx   = r_base + CFG_AW'(N_IN);
    assign w_wt     = r_wmem[w_widx];
    assign w_xin    = r_xmem[r_k];
    assign w_bias   = r_wmem[w_bidx];
    assign w_wt_ext = {{DATA_W{w_wt[DATA_W-1]}}, w_wt};
    assign w_x_ext  = {{DATA_W{w_xin[DATA_W-1]}}, w_xin};
    assign w_prod   = w_wt_ext * w_x_ext;
    assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // ---------------- Bias, rescale, saturate ----------------
    assign w_bias_ext = {{(ACC_W - DATA_W - FRAC_W){w_bias[DATA_W-1]}}, w_bias, {FRAC_W{1'b0}}};
    assign w_sum      = r_acc + w_bias_ext;
    assign w_shift    = w_sum >>> FRAC_W;
    // The value fits DATA_W iff all bits from the DATA_W sign bit upward agree.
    assign w_hi       = w_shift[ACC_W-1:DATA_W-1];

    always_comb begin
        w_s = w_shift[DATA_W-1:0];
        if (!((&w_hi) || (~|w_hi))) begin
            w_s = w_shift[ACC_W-1] ? {1'b1, {(DATA_W - 1){1'b0}}}
                                   : {1'b0, {(DATA_W - 1){1'b1}}};
        end
    end

    // ---------------- Activations ----------------
    assign w_s_wide  = {w_s[DATA_W-1], w_s};
    assign w_sig_pre = (w_s_wide >>> 2) + SIG_HALF;

    always_comb begin
        w_sig = w_sig_pre[DATA_W-1:0];
        if (w_sig_pre[DATA_W]) begin
            w_sig = '0;
        end else if (w_sig_pre > SIG_ONE) begin
            w_sig = SIG_ONE[DATA_W-1:0];
        end
    end

    always_comb begin
        w_act = w_sig;
`ifdef FXP_ACT_SEL_EN
        case (r_act_sel)
            2'd1:    w_act = w_s[DATA_W-1] ? '0 : w_s;
            2'd2:    w_act = w_s;
            default: w_act = w_sig;
        endcase
`endif
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (bus.start) w_state_next = StMac;
            StMac:   if (w_k_last) w_state_next = StAct;
            StAct:   w_state_next = w_neuron_last ? StFin : StMac;
            StFin:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // ---------------- Datapath and storage ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) r_wmem[i] <= '0;
            for (int i = 0; i < int'(N_IN); i++)  r_xmem[i] <= '0;
            for (int i = 0; i < int'(N_OUT); i++) r_out[i]  <= '0;
            r_out_data    <= '0;
            r_acc         <= '0;
            r_neuron      <= '0;
            r_k           <= '0;
            r_base        <= '0;
            r_cycle_count <= '0;
`ifdef FXP_ACT_SEL_EN
            r_act_sel     <= 2'd0;
`endif
        end else begin
            // Writes are only accepted outside MAC/ACT, so operands stay frozen
            // for a whole evaluation; a write alongside start lands first.
            if (bus.cfg_we && !w_busy && (32'(bus.cfg_addr) < DEPTH)) begin
                r_wmem[bus.cfg_addr] <= bus.cfg_data;
            end
            if (bus.in_we && !w_busy && (32'(bus.in_addr) < N_IN)) begin
                r_xmem[bus.in_addr] <= bus.in_data;
            end

            r_out_data <= (32'(bus.out_addr) < N_OUT) ? r_out[bus.out_addr] : '0;

            case (r_state)
                StIdle: begin
                    if (w_start_ok) begin
                        r_neuron      <= '0;
                        r_k           <= '0;
                        r_base        <= '0;
                        r_acc         <= '0;
                        r_cycle_count <= '0;
`ifdef FXP_ACT_SEL_EN
                        r_act_sel     <= bus.act_sel;
`endif
                    end
                end
                StMac: begin
                    r_acc         <= r_acc + w_prod_ext;
                    r_k           <= w_k_last ? '0 : r_k + IN_AW'(1);
                    r_cycle_count <= r_cycle_count + 32'd1;
                end
                StAct: begin
                    r_out[r_neuron] <= w_act;
                    r_acc           <= '0;
                    r_k             <= '0;
                    r_cycle_count   <= r_cycle_count + 32'd1;
                    if (!w_neuron_last) begin
                        r_neuron <= r_neuron + NEU_W'(1);
                        r_base   <= r_base + CFG_AW'(N_IN + 1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = (r_state == StFin);
    assign bus.out_data    = r_out_data;
    assign bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_fxp_layer_engine.sv
module tb_fxp_layer_engine;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC_W = 10;
    localparam int unsigned N_IN   = 2;
    localparam int unsigned N_OUT  = 2;
    localparam int unsigned ACC_W  = 40;
    localparam int unsigned DEPTH  = N_OUT * (N_IN + 1);
    localparam int unsigned CFG_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IN_AW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int BUSY_CYC = N_OUT * (N_IN + 1);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fxp_layer_engine_if #(.DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT)) bus ();

    fxp_layer_engine #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .ACC_W  (ACC_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int w_m [DEPTH];
    int x_m [N_IN];
    int cur_sel = 0;
    logic signed [DATA_W-1:0] sb [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_w(input int n, input int k, input int val);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = CFG_AW'(n * (N_IN + 1) + k);
        bus.cfg_data = DATA_W'(val);
        tick();
        bus.cfg_we   = 1'b0;
        w_m[n * (N_IN + 1) + k] = val;
    endtask

    task automatic set_x(input int k, input int val);
        bus.in_we   = 1'b1;
        bus.in_addr = IN_AW'(k);
        bus.in_data = DATA_W'(val);
        tick();
        bus.in_we   = 1'b0;
        x_m[k] = val;
    endtask

    // Behavioural reference of one neuron in wide integer arithmetic.
    function automatic int ref_out(input int n, input int sel);
        longint acc;
        longint s;
        longint y;
        acc = longint'(w_m[n * (N_IN + 1) + N_IN]) * (longint'(1) << FRAC_W);
        for (int k = 0; k < int'(N_IN); k++) begin
            acc += longint'(w_m[n * (N_IN + 1) + k]) * longint'(x_m[k]);
        end
        s = acc >>> FRAC_W;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (sel == 1) return (s < 0) ? 0 : int'(s);
        if (sel == 2) return int'(s);
        y = (s >>> 2) + (longint'(1) << (FRAC_W - 1));
        if (y < 0) y = 0;
        if (y > (longint'(1) << FRAC_W)) y = longint'(1) << FRAC_W;
        return int'(y);
    endfunction

    task automatic expect_model();
        for (int n = 0; n < int'(N_OUT); n++) sb.push_back(DATA_W'(ref_out(n, cur_sel)));
    endtask

    task automatic expect2(input int a, input int b);
        sb.push_back(DATA_W'(a));
        sb.push_back(DATA_W'(b));
    endtask

    task automatic read_outputs(input string tag);
        logic signed [DATA_W-1:0] e;
        for (int n = 0; n < int'(N_OUT); n++) begin
            bus.out_addr = OUT_AW'(n);
            tick();
            if (sb.size() == 0) begin
                n_errors++;
                $error("FAIL %s_sb_empty: observed %0d expected queued value", tag, bus.out_data);
            end else begin
                e = sb.pop_front();
                check($sformatf("%s_out%0d", tag, n), bus.out_data, e);
            end
        end
    endtask

    // Pulse start (any same-cycle write already set up by the caller lands
    // with it), count busy cycles up to done, optionally inject a start plus
    // weight write while busy.
    task automatic run_eval(input string tag, input int inject_at);
        int  nb;
        bit  got_done;
        nb = 0;
        got_done = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        bus.in_we  = 1'b0;
        check({tag, "_busy_after_start"}, bus.busy, 1);
        for (int c = 0; c < 200 && !got_done; c++) begin
            if (bus.done) begin
                got_done = 1'b1;
                check({tag, "_busy_at_done"}, bus.busy, 0);
                check({tag, "_cycle_count"}, bus.cycle_count, BUSY_CYC);
            end else begin
                if (bus.busy) nb++;
                if (inject_at != 0 && bus.busy && nb == inject_at) begin
                    bus.start    = 1'b1;
                    bus.cfg_we   = 1'b1;
                    bus.cfg_addr = '0;
                    bus.cfg_data = -16'sd32768;
                end
                tick();
                bus.start  = 1'b0;
                bus.cfg_we = 1'b0;
            end
        end
        check({tag, "_done_seen"}, got_done, 1);
        check({tag, "_busy_cycles"}, nb, BUSY_CYC);
        tick();
        check({tag, "_done_one_cycle"}, bus.done, 0);
        check({tag, "_cycle_count_hold"}, bus.cycle_count, BUSY_CYC);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of run, expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ndone;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.in_we = 1'b0;  bus.in_addr = '0;  bus.in_data = '0;
        bus.start = 1'b0;  bus.out_addr = '0;
`ifdef FXP_ACT_SEL_EN
        bus.act_sel = 2'd0;
`endif
        for (int i = 0; i < int'(DEPTH); i++) w_m[i] = 0;
        for (int i = 0; i < int'(N_IN); i++)  x_m[i] = 0;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_cycle_count", bus.cycle_count, 0);

        // Reference network.
        set_w(0, 0, 20480);  set_w(0, 1, 20480);  set_w(0, 2, -10240);
        set_w(1, 0, -20480); set_w(1, 1, -20480); set_w(1, 2, 30720);

        set_x(0, 1024); set_x(1, 0);
        expect2(1024, 1024);
        run_eval("x10", 0);
        read_outputs("x10");

        set_x(0, 0); set_x(1, 0);
        expect2(0, 1024);
        run_eval("x00", 0);
        read_outputs("x00");

        set_x(0, 1024); set_x(1, 1024);
        expect2(1024, 0);
        run_eval("x11", 0);
        read_outputs("x11");

        // Mid-run start and weight write must both be ignored.
        expect2(1024, 0);
        run_eval("intf", 2);
        read_outputs("intf");
        expect2(1024, 0);
        run_eval("intf_rerun", 0);
        read_outputs("intf_rerun");

        // Weight write in the same cycle as start is used by this run.
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = '0;
        bus.cfg_data = -16'sd20480;
        w_m[0] = -20480;
        expect2(0, 0);
        run_eval("same_cyc_wr", 0);
        read_outputs("same_cyc_wr");

        // Saturation.
        for (int n = 0; n < int'(N_OUT); n++) begin
            set_w(n, 0, 32767); set_w(n, 1, 32767); set_w(n, 2, 0);
        end
        set_x(0, 32767); set_x(1, 32767);
        expect2(1024, 1024);
        run_eval("sat", 0);
        read_outputs("sat");
`ifdef FXP_ACT_SEL_EN
        bus.act_sel = 2'd2;
        expect2(32767, 32767);
        run_eval("sat_ident", 0);
        read_outputs("sat_ident");
        bus.act_sel = 2'd0;
`endif

        // Negative path.
        set_w(0, 0, 1024); set_w(0, 1, 0);    set_w(0, 2, 0);
        set_w(1, 0, 0);    set_w(1, 1, 1024); set_w(1, 2, 0);
        set_x(0, -3072); set_x(1, 0);
        expect2(0, 512);
        run_eval("neg3", 0);
        read_outputs("neg3");
`ifdef FXP_ACT_SEL_EN
        bus.act_sel = 2'd1;
        expect2(0, 0);
        run_eval("neg3_relu", 0);
        read_outputs("neg3_relu");
        bus.act_sel = 2'd0;
`endif
        set_x(0, -1024);
        expect2(256, 512);
        run_eval("neg1", 0);
        read_outputs("neg1");
`ifdef FXP_ACT_SEL_EN
        bus.act_sel = 2'd2;
        expect2(-1024, 0);
        run_eval("neg1_ident", 0);
        read_outputs("neg1_ident");
        bus.act_sel = 2'd0;
`endif

        // Random vectors against the reference model.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                set_w(i / int'(N_IN + 1), i % int'(N_IN + 1), int'($urandom_range(16383)) - 8192);
            end
            for (int k = 0; k < int'(N_IN); k++) set_x(k, int'($urandom_range(16383)) - 8192);
            expect_model();
            run_eval($sformatf("rnd%0d", r), 0);
            read_outputs($sformatf("rnd%0d", r));
        end

        // Reset in the third busy cycle aborts the run.
        bus.out_addr = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("abort_busy_before_reset", bus.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_out_data", bus.out_data, 0);
        check("abort_cycle_count", bus.cycle_count, 0);
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        for (int i = 0; i < int'(DEPTH); i++) w_m[i] = 0;
        for (int i = 0; i < int'(N_IN); i++)  x_m[i] = 0;
        expect2(0, 0);
        read_outputs("abort_outputs");
        // With every weight and bias cleared, any input gives s = 0 -> 0.5.
        set_x(0, 1024); set_x(1, 1024);
        expect2(512, 512);
        run_eval("abort_weights", 0);
        read_outputs("abort_weights");

        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
